// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared pixel width and 3x3 window index constants
// Used by the window generator and the median finder.
package median_pkg;

   localparam int DEFAULT_PIXEL_W = 8;

   // Row-major window positions: top, middle, bottom line; left, centre, right.
   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;
   localparam int WIN_SIZE = 9;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - fixed DEPTH-sample delay line on a circular RAM
// Storage is never reset; stale contents are masked downstream by the counters.
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] ptr_q;
   logic [AW-1:0] ptr_d;

   // The slot about to be overwritten holds the sample written DEPTH enables ago.
   assign dout = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q >= PTR_LAST) ? '0 : ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[ptr_q] <= din;
      end
      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/window_3x3_generator.sv
// rtl/window_3x3_generator.sv - raster stream to 3x3 interior window front end
// Two line buffers feed the right column of a shifting 3x3 register window.
module window_3x3_generator
   import median_pkg::*;
#(
   parameter int PIXEL_W    = DEFAULT_PIXEL_W,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [PIXEL_W-1:0] in_pixel,
   output logic               out_valid,
   output logic               out_eof,
   output logic [PIXEL_W-1:0] pixel0,
   output logic [PIXEL_W-1:0] pixel1,
   output logic [PIXEL_W-1:0] pixel2,
   output logic [PIXEL_W-1:0] pixel3,
   output logic [PIXEL_W-1:0] pixel4,
   output logic [PIXEL_W-1:0] pixel5,
   output logic [PIXEL_W-1:0] pixel6,
   output logic [PIXEL_W-1:0] pixel7,
   output logic [PIXEL_W-1:0] pixel8
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]      col_q, col_d, cur_col;
   logic [RW-1:0]      row_q, row_d, cur_row;
   logic [PIXEL_W-1:0] win_q [WIN_SIZE];
   logic [PIXEL_W-1:0] win_d [WIN_SIZE];
   logic               valid_q, valid_d;
   logic               eof_q, eof_d;
   logic [PIXEL_W-1:0] lb0_dout, lb1_dout;

   line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_W)) u_lb0 (
      .clk  (clk),
      .en   (in_valid),
      .din  (in_pixel),
      .dout (lb0_dout)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_W)) u_lb1 (
      .clk  (clk),
      .en   (in_valid),
      .din  (lb0_dout),
      .dout (lb1_dout)
   );

   always_comb begin
      // in_sof relocates the accepted pixel to (0,0), abandoning any partial frame.
      cur_col = in_sof ? '0 : col_q;
      cur_row = in_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      valid_d = 1'b0;
      eof_d   = 1'b0;
      if (in_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
         for (int l = 0; l < 3; l++) begin
            win_d[3*l]     = win_q[3*l + 1];
            win_d[3*l + 1] = win_q[3*l + 2];
         end
         win_d[WIN_TR] = lb1_dout;
         win_d[WIN_MR] = lb0_dout;
         win_d[WIN_BR] = in_pixel;
         valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
         eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
         for (int k = 0; k < WIN_SIZE; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         eof_q   <= eof_d;
         win_q   <= win_d;
      end
   end

   assign out_valid = valid_q;
   assign out_eof   = eof_q;
   assign pixel0    = win_q[WIN_TL];
   assign pixel1    = win_q[WIN_TC];
   assign pixel2    = win_q[WIN_TR];
   assign pixel3    = win_q[WIN_ML];
   assign pixel4    = win_q[WIN_MC];
   assign pixel5    = win_q[WIN_MR];
   assign pixel6    = win_q[WIN_BL];
   assign pixel7    = win_q[WIN_BC];
   assign pixel8    = win_q[WIN_BR];

endmodule

// File: tb/tb_window_3x3_generator.sv
// tb/tb_window_3x3_generator.sv - randomized bench for window_3x3_generator
// Expected windows are cut directly from a stored image of the accepted frame.
module tb_window_3x3_generator;

   localparam int W = 5;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_pixel;
   logic       out_valid;
   logic       out_eof;
   logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8;
   logic [7:0] obs_win [9];

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] img [H][W];
   logic [7:0] ewin [9];
   int         mr, mc;
   bit         ev, eeof, known;

   // Observation bookkeeping
   int         win_count, eof_count;
   bit         first_seen, gap_mode, prev_ov;
   logic [7:0] first_win [9];
   logic [7:0] last_win [9];

   window_3x3_generator #(.PIXEL_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_eof   (out_eof),
      .pixel0    (pixel0),
      .pixel1    (pixel1),
      .pixel2    (pixel2),
      .pixel3    (pixel3),
      .pixel4    (pixel4),
      .pixel5    (pixel5),
      .pixel6    (pixel6),
      .pixel7    (pixel7),
      .pixel8    (pixel8)
   );

   always #5 clk = ~clk;

   assign obs_win[0] = pixel0;
   assign obs_win[1] = pixel1;
   assign obs_win[2] = pixel2;
   assign obs_win[3] = pixel3;
   assign obs_win[4] = pixel4;
   assign obs_win[5] = pixel5;
   assign obs_win[6] = pixel6;
   assign obs_win[7] = pixel7;
   assign obs_win[8] = pixel8;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mr = 0; mc = 0; ev = 0; eeof = 0; known = 1;
      for (int k = 0; k < 9; k++) ewin[k] = 8'h00;
   endtask

   task automatic model_step(input bit v, input bit sof, input logic [7:0] pix);
      if (!v) begin
         ev = 0; eeof = 0;
         return;
      end
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
         ev = 1; known = 1;
         for (int k = 0; k < 9; k++) ewin[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
         eeof = (mr == H - 1) && (mc == W - 1);
      end else begin
         ev = 0; eeof = 0; known = 0;
      end
      mc++;
      if (mc == W) begin
         mc = 0; mr++;
         if (mr == H) mr = 0;
      end
   endtask

   task automatic compare_outputs();
      check("out_valid", out_valid, ev);
      check("out_eof", out_eof, eeof);
      if (known)
         for (int k = 0; k < 9; k++) check($sformatf("pixel%0d", k), obs_win[k], ewin[k]);
      if (gap_mode) check("no_back_to_back", out_valid & prev_ov, 0);
      prev_ov = out_valid;
      if (out_valid) begin
         win_count++;
         if (!first_seen) begin
            first_seen = 1;
            for (int k = 0; k < 9; k++) first_win[k] = obs_win[k];
         end
         if (out_eof) begin
            eof_count++;
            for (int k = 0; k < 9; k++) last_win[k] = obs_win[k];
         end
      end
   endtask

   task automatic do_cycle(input bit v, input bit sof, input logic [7:0] pix);
      in_valid = v; in_sof = sof; in_pixel = pix;
      @(posedge clk);
      model_step(v, sof, pix);
      #1;
      compare_outputs();
   endtask

   task automatic clear_stats();
      win_count = 0; eof_count = 0; first_seen = 0; prev_ov = 0;
   endtask

   // mode 0: row*16+col, 1: random, 2: all 0xFF with 0x00 at (1,1)
   task automatic drive_frame(input int mode, input bit gaps, input bit use_sof, input int stop_r, input int stop_c);
      logic [7:0] pix;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r == stop_r && c == stop_c) return;
            case (mode)
               0:       pix = 8'(r * 16 + c);
               1:       pix = 8'($urandom);
               default: pix = (r == 1 && c == 1) ? 8'h00 : 8'hFF;
            endcase
            do_cycle(1'b1, use_sof && r == 0 && c == 0, pix);
            if (gaps) do_cycle(1'b0, 1'b0, 8'($urandom));
         end
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      model_reset();
      compare_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
      gap_mode = 0;
      model_reset();
      clear_stats();
      @(posedge clk); #1;
      compare_outputs();
      rst = 1'b0;
      do_cycle(1'b0, 1'b0, 8'h00);

      // Continuous frame
      clear_stats();
      drive_frame(0, 0, 1, -1, -1);
      check("t1_windows", win_count, 6);
      check("t1_eofs", eof_count, 1);
      check("t1_first_p0", first_win[0], 8'h00);
      check("t1_first_p4", first_win[4], 8'h11);
      check("t1_first_p8", first_win[8], 8'h22);
      check("t1_last_p0", last_win[0], 8'h12);
      check("t1_last_p8", last_win[8], 8'h34);

      // Same frame with in_valid toggling
      clear_stats();
      gap_mode = 1;
      drive_frame(0, 1, 1, -1, -1);
      gap_mode = 0;
      check("t2_windows", win_count, 6);
      check("t2_first_p4", first_win[4], 8'h11);
      check("t2_last_p8", last_win[8], 8'h34);

      // Random frame followed by pattern frame
      clear_stats();
      drive_frame(1, 0, 1, -1, -1);
      first_seen = 0;
      drive_frame(0, 0, 1, -1, -1);
      check("t3_windows", win_count, 12);
      check("t3_eofs", eof_count, 2);
      check("t3_second_p4", first_win[4], 8'h11);

      // Random frame, then sof reasserted at (2,3)
      drive_frame(1, 0, 1, -1, -1);
      clear_stats();
      drive_frame(1, 0, 1, 2, 3);
      check("t4_partial_windows", win_count, 1);
      check("t4_partial_eofs", eof_count, 0);
      clear_stats();
      drive_frame(0, 0, 1, -1, -1);
      check("t4_windows", win_count, 6);
      check("t4_eofs", eof_count, 1);
      check("t4_first_p0", first_win[0], 8'h00);

      // Reset mid-line at (2,3); next frame has no sof to exercise counter reset
      drive_frame(0, 0, 1, 2, 3);
      pulse_reset();
      clear_stats();
      drive_frame(0, 0, 0, -1, -1);
      check("t5_windows", win_count, 6);
      check("t5_first_p4", first_win[4], 8'h11);

      // Extreme values
      clear_stats();
      drive_frame(2, 0, 1, -1, -1);
      check("t6_first_p4", first_win[4], 8'h00);
      check("t6_first_p0", first_win[0], 8'hFF);
      check("t6_first_p8", first_win[8], 8'hFF);

      // Random stream: sporadic gaps and mid-frame sof
      for (int i = 0; i < 400; i++)
         do_cycle(($urandom % 4) != 0, ($urandom % 40) == 0, 8'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
